// File: rtl/line_burst_adapter.sv
// Bridges line-granular arbiter requests onto a 64-bit bmem burst port: one read command with
// four collected beats, or four write beats, then a single-cycle completion pulse.
module line_burst_adapter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned BEAT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [LINE_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [LINE_WIDTH-1:0] resp_rdata,
  output logic [ADDR_WIDTH-1:0] bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [BEAT_WIDTH-1:0] bmem_wdata,
  input  logic                  bmem_ready,
  input  logic [ADDR_WIDTH-1:0] bmem_raddr,
  input  logic [BEAT_WIDTH-1:0] bmem_rdata,
  input  logic                  bmem_rvalid
);

  localparam int unsigned Beats = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned OffsW = $clog2(LINE_WIDTH / 8);
  localparam logic [CntW-1:0]       LastBeat = CntW'(Beats - 1);
  localparam logic [ADDR_WIDTH-1:0] OffsMask = ADDR_WIDTH'((1 << OffsW) - 1);

  typedef enum logic [2:0] {StIdle, StRdCmd, StRdCollect, StWrBeat, StResp} state_e;

  state_e                               state_q, state_d;
  logic [CntW-1:0]                      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]                addr_q, addr_d;
  logic [Beats-1:0][BEAT_WIDTH-1:0]     wdata_q, wdata_d;
  logic [Beats-1:0][BEAT_WIDTH-1:0]     rbuf_q, rbuf_d;
  logic [Beats-1:0][BEAT_WIDTH-1:0]     rline_q, rline_d;
  logic [ADDR_WIDTH-1:0]                aligned_addr;

  assign aligned_addr = req_addr & ~OffsMask;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    rline_d    = rline_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        // Read wins a tie; the write is left for the arbiter to re-present.
        if (req_read) begin
          addr_d  = aligned_addr;
          state_d = StRdCmd;
        end else if (req_write) begin
          addr_d  = aligned_addr;
          wdata_d = req_wdata;
          cnt_d   = '0;
          state_d = StWrBeat;
        end
      end
      StRdCmd: begin
        bmem_read = 1'b1;
        if (bmem_ready) begin
          cnt_d   = '0;
          state_d = StRdCollect;
        end
      end
      StRdCollect: begin
        if (bmem_rvalid && (bmem_raddr == addr_q)) begin
          rbuf_d[cnt_q] = bmem_rdata;
          cnt_d         = cnt_q + 1'b1;
          // Publish only a complete line so resp_rdata never shows a partial read.
          if (cnt_q == LastBeat) begin
            rline_d = rbuf_d;
            state_d = StResp;
          end
        end
      end
      StWrBeat: begin
        bmem_write = 1'b1;
        if (bmem_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastBeat) begin
            state_d = StResp;
          end
        end
      end
      StResp: begin
        resp_valid = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bmem_addr  = addr_q;
  assign bmem_wdata = wdata_q[cnt_q];
  assign resp_rdata = rline_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rbuf_q  <= rbuf_d;
      rline_q <= rline_d;
    end
  end

endmodule

// File: tb/tb_line_burst_adapter.sv
// Scoreboard bench for line_burst_adapter: directed stimulus pushes expected commands, beats and
// responses into queues; a negedge monitor pops and compares whatever the DUT presents.
module tb_line_burst_adapter;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int BW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] req_addr;
  logic          req_read, req_write;
  logic [LW-1:0] req_wdata;
  logic          req_ready, resp_valid;
  logic [LW-1:0] resp_rdata;
  logic [AW-1:0] bmem_addr;
  logic          bmem_read, bmem_write;
  logic [BW-1:0] bmem_wdata;
  logic          bmem_ready;
  logic [AW-1:0] bmem_raddr;
  logic [BW-1:0] bmem_rdata;
  logic          bmem_rvalid;

  always #5 clk = ~clk;

  line_burst_adapter dut (
    .clk        (clk),
    .rst        (rst),
    .req_addr   (req_addr),
    .req_read   (req_read),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_ready (bmem_ready),
    .bmem_raddr (bmem_raddr),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  localparam logic [LW-1:0] Line1 = {64'h4444444444444444, 64'h3333333333333333,
                                     64'h2222222222222222, 64'h1111111111111111};
  localparam logic [BW-1:0] WA = 64'hA1A1A1A1A1A1A1A1, WB = 64'hB2B2B2B2B2B2B2B2;
  localparam logic [BW-1:0] WC = 64'hC3C3C3C3C3C3C3C3, WD = 64'hD4D4D4D4D4D4D4D4;
  localparam logic [BW-1:0] G0 = 64'h0000000000000100, G1 = 64'h0000000000000101;
  localparam logic [BW-1:0] G2 = 64'h0000000000000102, G3 = 64'h0000000000000103;
  localparam logic [LW-1:0] LineG = {G3, G2, G1, G0};
  localparam logic [BW-1:0] S0 = 64'h5050505050505050, S1 = 64'h5151515151515151;
  localparam logic [BW-1:0] S2 = 64'h5252525252525252, S3 = 64'h5353535353535353;
  localparam logic [LW-1:0] LineS = {S3, S2, S1, S0};
  localparam logic [BW-1:0] V0 = 64'h7000000000000000, V1 = 64'h7100000000000001;
  localparam logic [BW-1:0] V2 = 64'h7200000000000002, V3 = 64'h7300000000000003;
  localparam logic [LW-1:0] LineV = {V3, V2, V1, V0};
  localparam logic [BW-1:0] Junk = 64'hDEADBEEFDEADBEEF;

  int checks = 0;
  int errors = 0;
  logic [LW-1:0]    exp_resp_q[$];
  logic [AW-1:0]    exp_cmd_q[$];
  logic [AW+BW-1:0] exp_wr_q[$];
  bit   mon_en = 1'b0;
  logic resp_prev = 1'b0;
  int   rd_cmd_cycles = 0;
  int   wr_cycles = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: compares every response, read command and write beat against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rst) begin
        if (resp_valid) begin
          chk("resp_single_pulse", LW'(resp_prev), LW'(1'b0));
          if (exp_resp_q.size() == 0) fail_now("unexpected_resp");
          else chk("resp_rdata", resp_rdata, exp_resp_q.pop_front());
        end
        resp_prev = resp_valid;
        if (bmem_read) begin
          rd_cmd_cycles++;
          if (exp_cmd_q.size() == 0) fail_now("unexpected_bmem_read");
          else begin
            chk("bmem_read_addr", LW'(bmem_addr), LW'(exp_cmd_q[0]));
            if (bmem_ready) void'(exp_cmd_q.pop_front());
          end
        end
        if (bmem_write) begin
          wr_cycles++;
          if (exp_wr_q.size() == 0) fail_now("unexpected_bmem_write");
          else begin
            chk("bmem_write_addr", LW'(bmem_addr), LW'(exp_wr_q[0][AW+BW-1:BW]));
            chk("bmem_wdata", LW'(bmem_wdata), LW'(exp_wr_q[0][BW-1:0]));
            if (bmem_ready) void'(exp_wr_q.pop_front());
          end
        end
      end else begin
        resp_prev = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [AW-1:0] ra, input logic [BW-1:0] d);
    bmem_rvalid = v;
    bmem_raddr  = ra;
    bmem_rdata  = d;
    tick();
    bmem_rvalid = 1'b0;
  endtask

  // Waits for the completion pulse, then drops the request in the following cycle.
  task automatic wait_resp(input string name);
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (resp_valid) break;
      n++;
      if (n > 40) begin
        fail_now({name, "_resp_timeout"});
        break;
      end
    end
    tick();
    req_read  = 1'b0;
    req_write = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req_addr = '0; req_read = 1'b0; req_write = 1'b0; req_wdata = '0;
    bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;

    // Reset
    tick(); tick();
    rst = 1'b1;
    chk("rst_req_ready", LW'(req_ready), LW'(1'b1));
    chk("rst_resp_valid", LW'(resp_valid), LW'(1'b0));
    chk("rst_bmem_read", LW'(bmem_read), LW'(1'b0));
    chk("rst_bmem_write", LW'(bmem_write), LW'(1'b0));
    chk("rst_resp_rdata", resp_rdata, '0);
    chk("rst_bmem_addr", LW'(bmem_addr), '0);
    chk("rst_bmem_wdata", LW'(bmem_wdata), '0);
    mon_en = 1'b1;
    tick();

    // Plain read with unaligned request address
    rd_cmd_cycles = 0;
    req_read = 1'b1; req_addr = 32'h1eceb004; bmem_ready = 1'b1;
    exp_cmd_q.push_back(32'h1eceb000);
    exp_resp_q.push_back(Line1);
    tick(); tick();
    beat(1'b1, 32'h1eceb000, 64'h1111111111111111);
    beat(1'b1, 32'h1eceb000, 64'h2222222222222222);
    beat(1'b1, 32'h1eceb000, 64'h3333333333333333);
    beat(1'b1, 32'h1eceb000, 64'h4444444444444444);
    wait_resp("read1");
    chk("read1_cmd_cycles", LW'(rd_cmd_cycles), LW'(1));

    // Write with a two-cycle stall on beat 1
    wr_cycles = 0;
    req_write = 1'b1; req_addr = 32'h00004010; req_wdata = {WD, WC, WB, WA};
    exp_wr_q.push_back({32'h00004000, WA});
    exp_wr_q.push_back({32'h00004000, WB});
    exp_wr_q.push_back({32'h00004000, WC});
    exp_wr_q.push_back({32'h00004000, WD});
    exp_resp_q.push_back(Line1);
    tick(); tick();
    bmem_ready = 1'b0;
    tick(); tick();
    bmem_ready = 1'b1;
    wait_resp("write_stall");
    chk("write_stall_cycles", LW'(wr_cycles), LW'(6));

    // Stray idle/cmd-phase beats, gaps and a mismatched tag
    beat(1'b1, 32'h00004000, Junk);
    req_read = 1'b1; req_addr = 32'h00004000;
    exp_cmd_q.push_back(32'h00004000);
    exp_resp_q.push_back(LineG);
    bmem_rvalid = 1'b1; bmem_raddr = 32'h00004000; bmem_rdata = Junk;
    tick(); tick();
    beat(1'b1, 32'h00004000, G0);
    beat(1'b0, 32'h00004000, Junk);
    beat(1'b1, 32'h00004000, G1);
    beat(1'b1, 32'h00005000, Junk);
    beat(1'b1, 32'h00004000, G2);
    beat(1'b0, 32'h00004000, Junk);
    beat(1'b1, 32'h00004000, G3);
    wait_resp("gapped_read");

    // Simultaneous read+write: read wins, write re-presented afterwards
    req_read = 1'b1; req_write = 1'b1; req_addr = 32'h1eceb020; req_wdata = {4{Junk}};
    exp_cmd_q.push_back(32'h1eceb020);
    exp_resp_q.push_back(LineS);
    tick(); tick();
    beat(1'b1, 32'h1eceb020, S0);
    beat(1'b1, 32'h1eceb020, S1);
    beat(1'b1, 32'h1eceb020, S2);
    beat(1'b1, 32'h1eceb020, S3);
    wait_resp("simul_read");
    chk("b2b_idle_ready", LW'(req_ready), LW'(1'b1));
    req_write = 1'b1; req_addr = 32'h00004004; req_wdata = {WA, WB, WC, WD};
    exp_wr_q.push_back({32'h00004000, WD});
    exp_wr_q.push_back({32'h00004000, WC});
    exp_wr_q.push_back({32'h00004000, WB});
    exp_wr_q.push_back({32'h00004000, WA});
    exp_resp_q.push_back(LineS);
    tick();
    chk("b2b_write_started", LW'(bmem_write), LW'(1'b1));
    wait_resp("b2b_write");

    // Reset in the middle of a read collection
    req_read = 1'b1; req_addr = 32'h00008000;
    exp_cmd_q.push_back(32'h00008000);
    tick(); tick();
    beat(1'b1, 32'h00008000, Junk);
    beat(1'b1, 32'h00008000, Junk);
    rst = 1'b0; req_read = 1'b0;
    bmem_rvalid = 1'b1; bmem_raddr = 32'h00008000; bmem_rdata = Junk;
    tick();
    chk("midrst_bmem_read", LW'(bmem_read), LW'(1'b0));
    chk("midrst_req_ready", LW'(req_ready), LW'(1'b1));
    chk("midrst_resp_rdata", resp_rdata, '0);
    rst = 1'b1;
    tick();
    bmem_rvalid = 1'b0;
    req_read = 1'b1; req_addr = 32'h00008008;
    exp_cmd_q.push_back(32'h00008000);
    exp_resp_q.push_back(LineV);
    tick(); tick();
    beat(1'b1, 32'h00008000, V0);
    beat(1'b1, 32'h00008000, V1);
    beat(1'b1, 32'h00008000, V2);
    beat(1'b1, 32'h00008000, V3);
    wait_resp("post_rst_read");
    tick(); tick();

    chk("resp_queue_drained", LW'(exp_resp_q.size()), LW'(0));
    chk("cmd_queue_drained", LW'(exp_cmd_q.size()), LW'(0));
    chk("wr_queue_drained", LW'(exp_wr_q.size()), LW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_burst_adapter.md
Name: line_burst_adapter

Overview:
Sits directly downstream of cache_arbiter, between the arbiter's line-granular memory port and the banked memory (bmem) 64-bit burst port. Converts one 256-bit line read into a single bmem read command plus a four-beat response collection. Converts one 256-bit line write into four consecutive 64-bit write beats. Returns a one-cycle response pulse to the arbiter for each completed request. One request is outstanding at a time.

Parameters:
ADDR_WIDTH, 32, byte address width
LINE_WIDTH, 256, cache line width in bits
BEAT_WIDTH, 64, bmem beat width; BEATS = LINE_WIDTH/BEAT_WIDTH = 4 (derived, must be integer)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-low reset (0 = reset)
req_addr  in  ADDR_WIDTH  line request address from arbiter
req_read  in  1  line read request, held until resp_valid
req_write  in  1  line write request, held until resp_valid
req_wdata  in  LINE_WIDTH  write line data
req_ready  out  1  adapter idle, can accept request
resp_valid  out  1  one-cycle completion pulse (read data valid / write done)
resp_rdata  out  LINE_WIDTH  assembled read line
bmem_addr  out  ADDR_WIDTH  line-aligned address to bmem
bmem_read  out  1  bmem read command
bmem_write  out  1  bmem write beat valid
bmem_wdata  out  BEAT_WIDTH  current write beat
bmem_ready  in  1  bmem accepts command/beat this cycle
bmem_raddr  in  ADDR_WIDTH  address tag of returning beat
bmem_rdata  in  BEAT_WIDTH  returning read beat
bmem_rvalid  in  1  read beat valid

Behaviour:
- Reset (rst==0 at posedge): state IDLE, beat counter 0, latched addr/wdata 0, resp_rdata 0.
  - Registered outputs are 0 from the next cycle on: resp_valid, bmem_read, bmem_write, bmem_wdata, bmem_addr.
  - req_ready = (state==IDLE), so it is 1 after reset.
- States: IDLE, RD_CMD, RD_COLLECT, WR_BEAT, RESP.
- IDLE:
  - If req_read is set: latch addr with bits [4:0] forced to 0, go to RD_CMD.
  - Else if req_write is set: latch addr (aligned) and req_wdata, counter=0, go to WR_BEAT.
  - If both are set, read wins. The write is not latched; the arbiter must re-present it later.
- RD_CMD: bmem_read=1, bmem_addr=latched addr. Handshake completes on a posedge where bmem_ready=1. Then counter=0 and go to RD_COLLECT. If bmem_ready stays low, hold indefinitely.
- RD_COLLECT:
  - On each cycle with bmem_rvalid=1 and bmem_raddr==latched addr: write bmem_rdata into slot [counter*64 +: 64] (beat 0 = bits 63:0), counter++.
  - Beats with a mismatched raddr are dropped. Gaps between beats are allowed.
  - After the beat with counter==3 is captured, go to RESP.
- WR_BEAT: bmem_write=1, bmem_addr=latched addr, bmem_wdata=latched wdata[counter*64 +: 64]. The counter advances only on posedges with bmem_ready=1. After beat 3 is accepted, go to RESP. While bmem_ready=0, beat data and address are held stable.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - For a read, resp_rdata holds the assembled line, and stays stable until the next read completes.
  - For a write, resp_rdata is unchanged.
- Requests presented while not in IDLE are ignored. The arbiter drops its request in the cycle after resp_valid.
- Back-to-back: a new request can be accepted in the cycle after RESP (IDLE). This gives a minimum spacing of one idle cycle.
- bmem_rvalid outside RD_COLLECT is ignored and does not corrupt resp_rdata.
- Counter is 2 bits. Wrap from 3 never occurs because the state exits first.
- Reset mid-operation aborts the transaction; partial beats are discarded. Beats arriving after reset are ignored per the IDLE rule.
- Minimum read latency, request accept to resp_valid, is 1 (RD_CMD) + 4 (beats) + 1 (RESP) cycles, with bmem_ready=1 and beats back-to-back starting the cycle after the command.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release -> req_ready=1, resp_valid/bmem_read/bmem_write=0, resp_rdata=0.
- Read: req_read=1, req_addr=0x1eceb004, bmem_ready=1; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with raddr=0x1eceb000 -> bmem_addr=0x1eceb000 with bmem_read for exactly 1 cycle; single resp_valid pulse; resp_rdata={0x44..,0x33..,0x22..,0x11..}.
- Write with stall: req_write=1, addr 0x00004010, wdata beats A,B,C,D; bmem_ready low for 2 cycles during beat 1 -> bmem_wdata sequence A,B,B,B,C,D; bmem_addr=0x00004000 throughout; resp_valid 1 cycle after D is accepted.
- Gapped/stray beats: read at 0x00004000; insert 1-cycle rvalid gaps, one beat with raddr 0x00005000, and rvalid while IDLE -> mismatched and idle beats ignored; line assembled only from 4 matching beats.
- Simultaneous and back-to-back: req_read and req_write both set at 0x1eceb020/0x00004004 -> read serviced first; after RESP, write re-presented is accepted on the next IDLE cycle and completes.
- Reset mid-read: assert rst=0 after 2 beats captured -> next cycle bmem_read=0, state IDLE; remaining beats ignored; a subsequent fresh read returns correct data with no stale beats.
